i2c_master: RTL and testbench

- Single-byte I2C controller (initiator) for driving I2C responders, e.g. the on-chip LED responder or bench models at 7'h4A.
- Per command it generates START, address+R/W, one data byte (written or read), then STOP.
- Open-drain style pins: outputs are active-low pull enables, so a top level maps them to uio_oe exactly as the responder does.
- Supports responder clock stretching; multi-master arbitration is not supported.

---
 rtl/i2c_master_if.sv | 26 ++
 rtl/i2c_master.sv | 146 ++++++++++++++
 tb/tb_i2c_master.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_if.sv
// Command/status handshake and open-drain pin bundle for the single-byte I2C initiator.
// Pin outputs are active-low pull enables: 0 pulls the line low, 1 releases it.
interface i2c_master_if;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       sda_o;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;

  modport master (
    input  start, addr, rw, wdata, scl_i, sda_i,
    output scl_o, sda_o, busy, done, ack_err, rdata
  );

  modport slave (
    output start, addr, rw, wdata, scl_i, sda_i,
    input  scl_o, sda_o, busy, done, ack_err, rdata
  );
endinterface

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, address+R/W, one data byte written or read, STOP.
// Every bus phase is built from SCL quarter periods of CLK_DIV clocks; responder clock stretching is honoured.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input logic          clk,
  input logic          reset,
  i2c_master_if.master bus
);
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP
  } state_t;

  state_t           state;
  logic [1:0]       q;
  logic [2:0]       bitn;
  logic [7:0]       sh;
  logic             rw_q;
  logic [7:0]       wdata_q;
  logic [DIV_W-1:0] div;
  logic             in_slot;
  logic             stretch;
  logic             tick;

  assign in_slot = (state == ADDR) || (state == ADDR_ACK) || (state == WDATA) ||
                   (state == WACK) || (state == RDATA) || (state == RNACK);
  // SCL has been released but a responder still holds it low: freeze the quarter.
  assign stretch = !bus.scl_i && ((in_slot && q == 2'd2) || (state == STOP && q == 2'd1));
  assign tick    = bus.busy && !stretch && (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      q           <= '0;
      bitn        <= '0;
      sh          <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      div         <= '0;
      bus.scl_o   <= 1'b1;
      bus.sda_o   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ack_err <= 1'b0;
      bus.rdata   <= '0;
    end else begin
      bus.done <= 1'b0;
      if (!bus.busy || stretch || tick) div <= '0;
      else                              div <= div + DIV_W'(1);

      case (state)
        IDLE: if (bus.start) begin
          sh          <= {bus.addr, bus.rw};
          rw_q        <= bus.rw;
          wdata_q     <= bus.wdata;
          bus.ack_err <= 1'b0;
          bus.busy    <= 1'b1;
          bitn        <= '0;
          q           <= '0;
          bus.scl_o   <= 1'b1;
          bus.sda_o   <= 1'b1;
          state       <= START;
        end

        START: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: bus.sda_o <= 1'b0;
            2'd2: bus.scl_o <= 1'b0;
            2'd3: begin
              bus.sda_o <= sh[7];
              state     <= ADDR;
            end
            default: ;
          endcase
        end

        ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd1) bus.scl_o <= 1'b1;
          // End of a bit slot: sample SDA, then pull SCL low and present the next bit.
          if (q == 2'd3) begin
            bus.scl_o <= 1'b0;
            case (state)
              ADDR, WDATA: begin
                sh        <= {sh[6:0], 1'b0};
                bitn      <= bitn + 3'd1;
                bus.sda_o <= (bitn == 3'd7) ? 1'b1 : sh[6];
                if (bitn == 3'd7) state <= (state == ADDR) ? ADDR_ACK : WACK;
              end
              ADDR_ACK: begin
                if (bus.sda_i) begin
                  bus.ack_err <= 1'b1;
                  bus.sda_o   <= 1'b0;
                  state       <= STOP;
                end else if (rw_q) begin
                  bus.sda_o <= 1'b1;
                  state     <= RDATA;
                end else begin
                  sh        <= wdata_q;
                  bus.sda_o <= wdata_q[7];
                  state     <= WDATA;
                end
              end
              WACK: begin
                if (bus.sda_i) bus.ack_err <= 1'b1;
                bus.sda_o <= 1'b0;
                state     <= STOP;
              end
              RDATA: begin
                sh        <= {sh[6:0], bus.sda_i};
                bitn      <= bitn + 3'd1;
                bus.sda_o <= 1'b1;
                if (bitn == 3'd7) state <= RNACK;
              end
              RNACK: begin
                bus.rdata <= sh;
                bus.sda_o <= 1'b0;
                state     <= STOP;
              end
              default: ;
            endcase
          end
        end

        STOP: if (tick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: bus.scl_o <= 1'b1;
            2'd1: bus.sda_o <= 1'b1;
            2'd3: begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= IDLE;
            end
            default: ;
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a responder/bus-monitor model on the wired-AND lines and a byte-level
// reference of the expected bus events, status and timing for each command.
module tb_i2c_master;
  localparam int         CLK_DIV   = 4;
  localparam logic [6:0] RESP_ADDR = 7'h4A;
  localparam int         EV_START  = 1000;
  localparam int         EV_STOP   = 2000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_master_if bus();
  i2c_master #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic hold;
  logic resp_sda_low;
  assign bus.scl_i = bus.scl_o & ~hold;
  assign bus.sda_i = bus.sda_o & ~resp_sda_low;

  bit         resp_present, resp_nack_data, resp_stretch;
  logic [7:0] resp_rbyte, resp_rx;
  int         log_q[$];
  int         exp_q[$];
  logic       exp_err;
  logic [7:0] exp_rdata;
  int         exp_len;
  bit         cur_hit, cur_rw, cur_stretch;
  logic [7:0] cur_w;
  int         n_cmp, n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Responder at RESP_ADDR plus bus monitor, evaluated on the falling clock edge.
  initial begin
    logic ps, pd, s, d;
    int bitcnt, byteidx, hold_cnt;
    logic [7:0] cur;
    bit rd_mode, addressed;
    ps = 1'b1; pd = 1'b1; bitcnt = 0; byteidx = 0; hold_cnt = 0; cur = '0;
    rd_mode = 1'b0; addressed = 1'b0; hold = 1'b0; resp_sda_low = 1'b0; resp_rx = '0;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) hold = 1'b0;
      end
      s = bus.scl_o & ~hold;
      d = bus.sda_o & ~resp_sda_low;
      if (reset) begin
        bitcnt = 0; byteidx = 0; addressed = 1'b0; resp_sda_low = 1'b0; hold = 1'b0; hold_cnt = 0;
      end else if (ps && s && pd && !d) begin
        log_q.push_back(EV_START);
        bitcnt = 0; byteidx = 0; rd_mode = 1'b0; addressed = 1'b0;
      end else if (ps && s && !pd && d) begin
        log_q.push_back(EV_STOP);
        bitcnt = 0; addressed = 1'b0; resp_sda_low = 1'b0;
      end else if (!ps && s) begin
        if (bitcnt < 8) cur = {cur[6:0], d};
        else if (bitcnt == 8) log_q.push_back(int'(cur) * 2 + int'(d));
        bitcnt++;
      end else if (ps && !s) begin
        resp_sda_low = 1'b0;
        if (bitcnt == 8) begin
          if (byteidx == 0) begin
            addressed    = resp_present && (cur[7:1] == RESP_ADDR);
            rd_mode      = cur[0];
            resp_sda_low = addressed;
            if (addressed && resp_stretch) begin
              hold = 1'b1;
              hold_cnt = 2 * CLK_DIV + 37;
            end
          end else if (addressed && !rd_mode) begin
            resp_rx      = cur;
            resp_sda_low = !resp_nack_data;
          end
        end else if (bitcnt == 9) begin
          bitcnt = 0;
          byteidx++;
          if (addressed && rd_mode && byteidx == 1) resp_sda_low = !resp_rbyte[7];
        end else if (bitcnt >= 1 && bitcnt <= 7 && addressed && rd_mode && byteidx == 1) begin
          resp_sda_low = !resp_rbyte[7 - bitcnt];
        end
      end
      ps = s;
      pd = d;
    end
  end

  // Expected bus events, status and busy length for one command, from the byte-level protocol.
  task automatic model(input logic [6:0] a, input bit r, input logic [7:0] w,
                       input bit present, input bit nack_d, input logic [7:0] rb);
    bit hit;
    int nbytes;
    hit = present && (a == RESP_ADDR);
    exp_q.delete();
    exp_q.push_back(EV_START);
    exp_q.push_back(int'({a, r}) * 2 + (hit ? 0 : 1));
    if (hit) exp_q.push_back(r ? int'(rb) * 2 + 1 : int'(w) * 2 + (nack_d ? 1 : 0));
    exp_q.push_back(EV_STOP);
    exp_err = !hit || (!r && nack_d);
    if (hit && r) exp_rdata = rb;
    nbytes  = hit ? 2 : 1;
    exp_len = (4 + nbytes * 9 * 4 + 4) * CLK_DIV;
  endtask

  task automatic issue(input logic [6:0] a, input bit r, input logic [7:0] w);
    bus.start = 1'b1; bus.addr = a; bus.rw = r; bus.wdata = w;
    @(negedge clk);
    bus.start = 1'b0;
    bus.addr  = 7'($urandom_range(0, 127));
    bus.rw    = 1'($urandom_range(0, 1));
    bus.wdata = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(output int len);
    len = 0;
    while (bus.busy && len < 5000) begin
      @(negedge clk);
      len++;
    end
  endtask

  task automatic run_begin(input logic [6:0] a, input bit r, input logic [7:0] w, input bit present,
                           input bit nack_d, input logic [7:0] rb, input bit stretch);
    cur_hit = present && (a == RESP_ADDR);
    cur_rw = r; cur_w = w; cur_stretch = stretch && cur_hit;
    resp_present = present; resp_nack_data = nack_d; resp_rbyte = rb; resp_stretch = stretch;
    log_q.delete();
    model(a, r, w, present, nack_d, rb);
    issue(a, r, w);
    check("busy_rise", bus.busy, 1'b1);
  endtask

  task automatic run_end(input int already);
    int len, n;
    wait_done(len);
    len += already;
    check("busy_fall", bus.busy, 1'b0);
    check("done", bus.done, 1'b1);
    check("ack_err", bus.ack_err, exp_err);
    check("rdata", bus.rdata, exp_rdata);
    if (cur_stretch) begin
      check("len_min", len >= exp_len + 37, 1'b1);
      check("len_max", len <= exp_len + 40, 1'b1);
    end else begin
      check("busy_len", len, exp_len);
    end
    check("ev_count", log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("bus_event", log_q[i], exp_q[i]);
    if (cur_hit && !cur_rw) check("resp_rx", resp_rx, cur_w);
  endtask

  task automatic run(input logic [6:0] a, input bit r, input logic [7:0] w, input bit present,
                     input bit nack_d, input logic [7:0] rb, input bit stretch);
    run_begin(a, r, w, present, nack_d, rb, stretch);
    run_end(0);
    @(negedge clk);
    check("done_pulse", bus.done, 1'b0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, observed busy=%0b, expected 0", bus.busy);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    logic [6:0] a;
    n_cmp = 0; n_bad = 0; exp_rdata = '0;
    bus.start = 1'b0; bus.addr = '0; bus.rw = 1'b0; bus.wdata = '0;
    resp_present = 1'b0; resp_nack_data = 1'b0; resp_stretch = 1'b0; resp_rbyte = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scl", bus.scl_o, 1'b1);
    check("rst_sda", bus.sda_o, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ack_err", bus.ack_err, 1'b0);
    check("rst_rdata", bus.rdata, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    run(7'h4A, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    run(7'h4A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0);
    run(7'h21, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
    run(7'h4A, 1'b0, 8'h5E, 1'b1, 1'b0, 8'h00, 1'b1);
    run(7'h4A, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 1'b0);

    // A start strobe mid-transfer is ignored; the follow-up is issued the cycle after done.
    run_begin(7'h4A, 1'b1, 8'h00, 1'b1, 1'b0, 8'hD2, 1'b0);
    repeat (100) @(negedge clk);
    bus.start = 1'b1; bus.addr = 7'h11; bus.rw = 1'b0; bus.wdata = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    run_end(101);
    run_begin(7'h4A, 1'b0, 8'h69, 1'b1, 1'b0, 8'h00, 1'b0);
    run_end(0);
    @(negedge clk);
    check("done_pulse", bus.done, 1'b0);

    // Reset lands in the fourth WDATA slot, quarter 0.
    w = 8'hC3;
    run_begin(7'h4A, 1'b0, w, 1'b1, 1'b0, 8'h00, 1'b0);
    repeat (208) @(negedge clk);
    check("pre_rst_scl", bus.scl_o, 1'b0);
    check("pre_rst_sda", bus.sda_o, w[4]);
    #2 reset = 1'b1;
    #1;
    check("async_rst_scl", bus.scl_o, 1'b1);
    check("async_rst_sda", bus.sda_o, 1'b1);
    check("async_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = '0;
    check("rst_rdata_clear", bus.rdata, exp_rdata);
    @(negedge clk);
    run(7'h4A, 1'b0, 8'h3E, 1'b1, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 1) == 0) ? RESP_ADDR : 7'($urandom_range(0, 127));
      run(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
